// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types, default widths and accumulator sizing for the convolution controller
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    RD_K,
    WT_K,
    RD_I,
    WT_I,
    EMIT,
    FIN
  } convState_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DIM_W  = 10;
  localparam int DEF_MAX_K  = 7;

  // Product of two signed elements plus headroom for K*K taps.
  function automatic int accWidth(input int dataW, input int maxK);
    return 2 * dataW + $clog2(maxK * maxK);
  endfunction

endpackage

// File: rtl/convo_ctrl_p_if.sv
// rtl/convo_ctrl_p_if.sv - memory read bus and result stream of the convolution controller
interface convo_ctrl_p_if import conv_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = accWidth(DEF_DATA_W, DEF_MAX_K)
) ();

  logic              MemRd;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemRdata;
  logic              MemRvalid;
  logic              OutValid;
  logic              OutReady;
  logic [ACC_W-1:0]  OutData;

  // Controller side: issues reads, produces results.
  modport master (
    output MemRd, MemAddr, OutValid, OutData,
    input  MemRdata, MemRvalid, OutReady
  );

  // Memory arbiter / result writer side.
  modport slave (
    input  MemRd, MemAddr, OutValid, OutData,
    output MemRdata, MemRvalid, OutReady
  );

endinterface

// File: rtl/conv_addr_gen.sv
// rtl/conv_addr_gen.sv - output-pixel and kernel-tap counters with kernel/image address generation
module conv_addr_gen #(
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 10
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              clear,
  input  logic              tapAdv,
  input  logic              pixAdv,
  input  logic [3:0]        kSize,
  input  logic [1:0]        stride,
  input  logic [DIM_W-1:0]  imgW,
  input  logic [DIM_W-1:0]  outW,
  input  logic [DIM_W-1:0]  outH,
  input  logic [ADDR_W-1:0] imgBase,
  input  logic [ADDR_W-1:0] kerBase,
  output logic [ADDR_W-1:0] kernAddr,
  output logic [ADDR_W-1:0] imgAddr,
  output logic              lastTap,
  output logic              lastPix
);

  logic [DIM_W-1:0] oy, ox;
  logic [3:0]       ky, kx;
  logic             kxWrap, oxWrap;

  assign kxWrap  = (kx == kSize - 4'd1);
  assign lastTap = kxWrap && (ky == kSize - 4'd1);
  assign oxWrap  = (ox == outW - DIM_W'(1));
  assign lastPix = oxWrap && (oy == outH - DIM_W'(1));

  // Addresses are formed at full address width; wrap-around is allowed.
  assign kernAddr = kerBase + ADDR_W'(ky) * ADDR_W'(kSize) + ADDR_W'(kx);
  assign imgAddr  = imgBase
                  + (ADDR_W'(oy) * ADDR_W'(stride) + ADDR_W'(ky)) * ADDR_W'(imgW)
                  + ADDR_W'(ox) * ADDR_W'(stride) + ADDR_W'(kx);

  // Tap counters step kx then ky; pixel counters step ox then oy (raster order).
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      oy <= '0;
      ox <= '0;
      ky <= '0;
      kx <= '0;
    end else if (clear) begin
      oy <= '0;
      ox <= '0;
      ky <= '0;
      kx <= '0;
    end else if (pixAdv) begin
      ky <= '0;
      kx <= '0;
      if (oxWrap) begin
        ox <= '0;
        oy <= oy + DIM_W'(1);
      end else begin
        ox <= ox + DIM_W'(1);
      end
    end else if (tapAdv) begin
      if (kxWrap) begin
        kx <= '0;
        ky <= lastTap ? 4'd0 : ky + 4'd1;
      end else begin
        kx <= kx + 4'd1;
      end
    end
  end

endmodule

// File: rtl/convo_ctrl_p.sv
// rtl/convo_ctrl_p.sv - valid-mode strided 2-D convolution controller with one read in flight
module convo_ctrl_p import conv_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DIM_W  = DEF_DIM_W,
  parameter int MAX_K  = DEF_MAX_K,
  parameter int ACC_W  = accWidth(DATA_W, MAX_K)
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic [ADDR_W-1:0] ImageAddress,
  input  logic [ADDR_W-1:0] KernelAddress,
  input  logic [3:0]        KernelSize,
  input  logic [DIM_W-1:0]  ImageWidth,
  input  logic [DIM_W-1:0]  ImageHeight,
  input  logic [1:0]        Stride,
  convo_ctrl_p_if.master    bus,
  output logic              Busy,
  output logic              Done,
  output logic              Err
);

  convState_t state, nextState;

  logic [ADDR_W-1:0]        cfgImgAddr, cfgKerAddr;
  logic [3:0]               cfgK;
  logic [DIM_W-1:0]         cfgW, cfgH;
  logic [1:0]               cfgS;
  logic signed [DATA_W-1:0] weight;
  logic signed [ACC_W-1:0]  acc;
  logic signed [2*DATA_W-1:0] product;
  logic                     cfgBad;
  logic [DIM_W-1:0]         strideDiv, outW, outH;
  logic                     ctrClear, tapAdv, pixAdv, lastTap, lastPix;
  logic [ADDR_W-1:0]        kernAddr, imgAddr;

  assign cfgBad = (cfgK == 4'd0) || (int'(cfgK) > MAX_K) ||
                  (DIM_W'(cfgK) > cfgW) || (DIM_W'(cfgK) > cfgH) || (cfgS == 2'd0);

  // Divisor guarded so a zero stride never reaches the divider; the result is unused then.
  assign strideDiv = (cfgS == 2'd0) ? DIM_W'(1) : DIM_W'(cfgS);
  assign outW      = (cfgW - DIM_W'(cfgK)) / strideDiv + DIM_W'(1);
  assign outH      = (cfgH - DIM_W'(cfgK)) / strideDiv + DIM_W'(1);

  assign product = weight * $signed(bus.MemRdata);

  conv_addr_gen #(
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W)
  ) uAddrGen (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .clear    (ctrClear),
    .tapAdv   (tapAdv),
    .pixAdv   (pixAdv),
    .kSize    (cfgK),
    .stride   (cfgS),
    .imgW     (cfgW),
    .outW     (outW),
    .outH     (outH),
    .imgBase  (cfgImgAddr),
    .kerBase  (cfgKerAddr),
    .kernAddr (kernAddr),
    .imgAddr  (imgAddr),
    .lastTap  (lastTap),
    .lastPix  (lastPix)
  );

  // FSM state register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state decode and all handshake/status outputs.
  always_comb begin
    nextState    = state;
    bus.MemRd    = 1'b0;
    bus.MemAddr  = '0;
    bus.OutValid = 1'b0;
    bus.OutData  = '0;
    Busy         = (state != IDLE);
    Done         = 1'b0;
    ctrClear     = 1'b0;
    tapAdv       = 1'b0;
    pixAdv       = 1'b0;
    case (state)
      IDLE:  if (Start) nextState = CHECK;
      CHECK: begin
        ctrClear  = !cfgBad;
        nextState = cfgBad ? FIN : RD_K;
      end
      RD_K: begin
        bus.MemRd   = 1'b1;
        bus.MemAddr = kernAddr;
        nextState   = WT_K;
      end
      WT_K:  if (bus.MemRvalid) nextState = RD_I;
      RD_I: begin
        bus.MemRd   = 1'b1;
        bus.MemAddr = imgAddr;
        nextState   = WT_I;
      end
      WT_I: begin
        if (bus.MemRvalid) begin
          tapAdv    = 1'b1;
          nextState = lastTap ? EMIT : RD_K;
        end
      end
      EMIT: begin
        bus.OutValid = 1'b1;
        bus.OutData  = acc;
        if (bus.OutReady) begin
          pixAdv    = 1'b1;
          nextState = lastPix ? FIN : RD_K;
        end
      end
      FIN: begin
        Done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Job configuration is captured once so inputs may change while busy.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cfgImgAddr <= '0;
      cfgKerAddr <= '0;
      cfgK       <= '0;
      cfgW       <= '0;
      cfgH       <= '0;
      cfgS       <= '0;
    end else if (state == IDLE && Start) begin
      cfgImgAddr <= ImageAddress;
      cfgKerAddr <= KernelAddress;
      cfgK       <= KernelSize;
      cfgW       <= ImageWidth;
      cfgH       <= ImageHeight;
      cfgS       <= Stride;
    end
  end

  // Err is sticky from a rejected configuration until the next accepted Start.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                            Err <= 1'b0;
    else if (state == IDLE && Start)       Err <= 1'b0;
    else if (state == CHECK && cfgBad)     Err <= 1'b1;
  end

  // Weight capture and signed multiply-accumulate over the kernel taps.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      weight <= '0;
      acc    <= '0;
    end else begin
      if (state == WT_K && bus.MemRvalid) weight <= $signed(bus.MemRdata);
      if (state == CHECK)
        acc <= '0;
      else if (state == WT_I && bus.MemRvalid)
        acc <= acc + {{(ACC_W-2*DATA_W){product[2*DATA_W-1]}}, product};
      else if (state == EMIT && bus.OutReady)
        acc <= '0;
    end
  end

endmodule

// File: tb/tb_convo_ctrl_p.sv
// tb/tb_convo_ctrl_p.sv - scoreboard bench for the convolution controller
module tb_convo_ctrl_p;
  import conv_pkg::*;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 32;
  localparam int DIM_W     = 10;
  localparam int MAX_K     = 7;
  localparam int ACC_W     = accWidth(DATA_W, MAX_K);
  localparam int IMG_BASE  = 100;
  localparam int KER_BASE  = 600;
  localparam int MEM_WORDS = 1024;

  logic              Clk = 1'b0;
  logic              Rst_n = 1'b0;
  logic              Start = 1'b0;
  logic [ADDR_W-1:0] ImageAddress = '0;
  logic [ADDR_W-1:0] KernelAddress = '0;
  logic [3:0]        KernelSize = '0;
  logic [DIM_W-1:0]  ImageWidth = '0;
  logic [DIM_W-1:0]  ImageHeight = '0;
  logic [1:0]        Stride = '0;
  logic              Busy, Done, Err;

  convo_ctrl_p_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

  convo_ctrl_p #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W), .MAX_K(MAX_K), .ACC_W(ACC_W)
  ) dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .Start         (Start),
    .ImageAddress  (ImageAddress),
    .KernelAddress (KernelAddress),
    .KernelSize    (KernelSize),
    .ImageWidth    (ImageWidth),
    .ImageHeight   (ImageHeight),
    .Stride        (Stride),
    .bus           (bus),
    .Busy          (Busy),
    .Done          (Done),
    .Err           (Err)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  logic signed [DATA_W-1:0] mem [MEM_WORDS];
  int expQ[$];
  int gotQ[$];

  bit randLat = 1'b0;
  bit pending = 1'b0;
  int pendAddr = 0;
  int waitCnt = 0;
  int overlapCount = 0;

  // Memory model: one response per request, 1 + (0..5 random) cycles later.
  initial begin
    bus.MemRvalid = 1'b0;
    bus.MemRdata  = '0;
    forever begin
      @(negedge Clk);
      bus.MemRvalid = 1'b0;
      if (!Rst_n) begin
        pending = 1'b0;
      end else begin
        if (pending) begin
          if (waitCnt == 0) begin
            bus.MemRvalid = 1'b1;
            if (pendAddr >= 0 && pendAddr < MEM_WORDS) bus.MemRdata = mem[pendAddr];
            else bus.MemRdata = '0;
            pending = 1'b0;
          end else begin
            waitCnt--;
          end
        end
        if (bus.MemRd) begin
          if (pending) overlapCount++;
          pending  = 1'b1;
          pendAddr = int'(bus.MemAddr);
          waitCnt  = randLat ? int'($urandom_range(0, 5)) : 0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog global time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clearMem();
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = '0;
  endtask

  task automatic loadRamp();
    clearMem();
    for (int i = 0; i < 16; i++) mem[IMG_BASE + i] = 8'(i + 1);
    for (int i = 0; i < 4; i++) mem[KER_BASE + i] = 8'sd1;
  endtask

  task automatic pushModel(input int k, input int w, input int h, input int s);
    int ow, oh, sum;
    ow = (w - k) / s + 1;
    oh = (h - k) / s + 1;
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++) begin
        sum = 0;
        for (int ky = 0; ky < k; ky++)
          for (int kx = 0; kx < k; kx++)
            sum += int'(mem[KER_BASE + ky * k + kx]) *
                   int'(mem[IMG_BASE + (oy * s + ky) * w + ox * s + kx]);
        expQ.push_back(sum);
      end
  endtask

  task automatic driveCfg(input int k, input int w, input int h, input int s);
    ImageAddress  = ADDR_W'(IMG_BASE);
    KernelAddress = ADDR_W'(KER_BASE);
    KernelSize    = 4'(k);
    ImageWidth    = DIM_W'(w);
    ImageHeight   = DIM_W'(h);
    Stride        = 2'(s);
  endtask

  // Runs one job with OutReady high, collecting every transferred result into gotQ.
  task automatic runJob(input int k, input int w, input int h, input int s, input bit midStart,
                        output int dones, output bit busyAfter, output bit timedOut);
    dones = 0;
    busyAfter = 1'b1;
    timedOut = 1'b1;
    @(negedge Clk);
    driveCfg(k, w, h, s);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if (midStart && cyc == 30) begin
        Start = 1'b1;
        KernelSize = 4'd1;
        Stride = 2'd3;
        ImageWidth = DIM_W'(9);
      end
      if (midStart && cyc == 31) Start = 1'b0;
      if (bus.OutValid && bus.OutReady) gotQ.push_back(int'($signed(bus.OutData)));
      if (Done) begin
        dones++;
        @(negedge Clk);
        Start = 1'b0;
        busyAfter = Busy;
        if (Done) dones++;
        timedOut = 1'b0;
        break;
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    bus.OutReady = 1'b1;
    repeat (3) @(negedge Clk);
    checks++; if (bus.MemRd !== 1'b0) begin failures++; $display("FAIL reset_memrd got=%b want=0", bus.MemRd); end
    checks++; if (bus.MemAddr !== '0) begin failures++; $display("FAIL reset_memaddr got=%0h want=0", bus.MemAddr); end
    checks++; if (bus.OutValid !== 1'b0) begin failures++; $display("FAIL reset_outvalid got=%b want=0", bus.OutValid); end
    checks++; if (bus.OutData !== '0) begin failures++; $display("FAIL reset_outdata got=%0h want=0", bus.OutData); end
    checks++; if ({Busy, Done, Err} !== 3'b000) begin failures++; $display("FAIL reset_status got=%b want=000", {Busy, Done, Err}); end
    Rst_n = 1'b1;
    @(negedge Clk);
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b want=0", Busy); end
  endtask

  task automatic test_basic();
    int lit[9] = '{14, 18, 22, 30, 34, 38, 46, 50, 54};
    int dones, e, g;
    bit busyAfter, timedOut;
    loadRamp();
    expQ.delete(); gotQ.delete();
    foreach (lit[i]) expQ.push_back(lit[i]);
    runJob(2, 4, 4, 1, 1'b0, dones, busyAfter, timedOut);
    checks++; if (timedOut) begin failures++; $display("FAIL basic_timeout got=1 want=0"); end
    checks++; if (gotQ.size() != 9) begin failures++; $display("FAIL basic_count got=%0d want=9", gotQ.size()); end
    while (expQ.size() > 0 && gotQ.size() > 0) begin
      e = expQ.pop_front(); g = gotQ.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL basic_data got=%0d want=%0d", g, e); end
    end
    checks++; if (dones != 1) begin failures++; $display("FAIL basic_done_pulses got=%0d want=1", dones); end
    checks++; if (busyAfter !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b want=0", busyAfter); end
    checks++; if (Err !== 1'b0) begin failures++; $display("FAIL basic_err got=%b want=0", Err); end
  endtask

  task automatic test_stride();
    int lit[4] = '{14, 22, 46, 54};
    int dones, e, g;
    bit busyAfter, timedOut;
    loadRamp();
    expQ.delete(); gotQ.delete();
    foreach (lit[i]) expQ.push_back(lit[i]);
    runJob(2, 4, 4, 2, 1'b0, dones, busyAfter, timedOut);
    checks++; if (gotQ.size() != 4) begin failures++; $display("FAIL stride_count got=%0d want=4", gotQ.size()); end
    while (expQ.size() > 0 && gotQ.size() > 0) begin
      e = expQ.pop_front(); g = gotQ.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL stride_data got=%0d want=%0d", g, e); end
    end
    checks++; if (dones != 1 || timedOut) begin failures++; $display("FAIL stride_done got=%0d want=1", dones); end
  endtask

  task automatic test_signed_backpressure();
    int held, unstable, e, g;
    bit seen;
    clearMem();
    for (int i = 0; i < 9; i++) begin
      mem[IMG_BASE + i] = -8'sd128;
      mem[KER_BASE + i] = 8'sd127;
    end
    expQ.delete(); gotQ.delete();
    expQ.push_back(-146304);
    bus.OutReady = 1'b0;
    @(negedge Clk);
    driveCfg(3, 3, 3, 1);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (bus.OutValid) begin seen = 1'b1; break; end
      @(negedge Clk);
    end
    checks++; if (!seen) begin failures++; $display("FAIL signed_outvalid_timeout got=0 want=1"); end
    held = int'($signed(bus.OutData));
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (bus.OutValid !== 1'b1 || int'($signed(bus.OutData)) != held) unstable++;
    end
    checks++; if (unstable != 0) begin failures++; $display("FAIL signed_stall_stable got=%0d want=0", unstable); end
    bus.OutReady = 1'b1;
    if (bus.OutValid) gotQ.push_back(int'($signed(bus.OutData)));
    checks++; if (gotQ.size() != 1) begin failures++; $display("FAIL signed_count got=%0d want=1", gotQ.size()); end
    while (expQ.size() > 0 && gotQ.size() > 0) begin
      e = expQ.pop_front(); g = gotQ.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL signed_data got=%0d want=%0d", g, e); end
    end
    @(negedge Clk);
    checks++; if ({bus.OutValid, Done} !== 2'b01) begin failures++; $display("FAIL signed_after_xfer got=%b want=01", {bus.OutValid, Done}); end
    @(negedge Clk);
  endtask

  task automatic test_config_error();
    int ks[2] = '{0, 5};
    int doneAt;
    bit sawRd, sawValid;
    foreach (ks[c]) begin
      @(negedge Clk);
      driveCfg(ks[c], 4, 4, 1);
      Start = 1'b1;
      doneAt = -1; sawRd = 1'b0; sawValid = 1'b0;
      for (int i = 1; i <= 6; i++) begin
        @(negedge Clk);
        Start = 1'b0;
        if (bus.MemRd) sawRd = 1'b1;
        if (bus.OutValid) sawValid = 1'b1;
        if (Done && doneAt < 0) doneAt = i;
      end
      checks++; if (doneAt != 2) begin failures++; $display("FAIL err_done_latency k=%0d got=%0d want=2", ks[c], doneAt); end
      checks++; if (Err !== 1'b1) begin failures++; $display("FAIL err_flag k=%0d got=%b want=1", ks[c], Err); end
      checks++; if (sawRd || sawValid) begin failures++; $display("FAIL err_no_activity k=%0d got=%b%b want=00", ks[c], sawRd, sawValid); end
    end
  endtask

  task automatic test_var_latency();
    int dones, e, g;
    bit busyAfter, timedOut;
    loadRamp();
    expQ.delete(); gotQ.delete();
    pushModel(2, 4, 4, 1);
    overlapCount = 0;
    randLat = 1'b1;
    runJob(2, 4, 4, 1, 1'b1, dones, busyAfter, timedOut);
    randLat = 1'b0;
    checks++; if (timedOut) begin failures++; $display("FAIL varlat_timeout got=1 want=0"); end
    checks++; if (gotQ.size() != 9) begin failures++; $display("FAIL varlat_count got=%0d want=9", gotQ.size()); end
    while (expQ.size() > 0 && gotQ.size() > 0) begin
      e = expQ.pop_front(); g = gotQ.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL varlat_data got=%0d want=%0d", g, e); end
    end
    checks++; if (overlapCount != 0) begin failures++; $display("FAIL varlat_outstanding got=%0d want=0", overlapCount); end
    checks++; if (dones != 1) begin failures++; $display("FAIL varlat_done got=%0d want=1", dones); end
    checks++; if (Err !== 1'b0) begin failures++; $display("FAIL varlat_err_cleared got=%b want=0", Err); end
    @(negedge Clk);
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL varlat_no_restart got=%b want=0", Busy); end
  endtask

  task automatic test_reset_mid();
    int outs, dones, e, g;
    bit found, busyAfter, timedOut;
    loadRamp();
    expQ.delete(); gotQ.delete();
    @(negedge Clk);
    driveCfg(2, 4, 4, 1);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    outs = 0; found = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (bus.OutValid && bus.OutReady) outs++;
      if (outs == 2 && bus.MemRd && int'(bus.MemAddr) >= IMG_BASE && int'(bus.MemAddr) < IMG_BASE + 16) begin
        found = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    checks++; if (!found) begin failures++; $display("FAIL rstmid_reach_third got=0 want=1"); end
    @(posedge Clk);
    #1;
    Rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.MemRd, bus.OutValid, Busy, Done, Err} !== 5'b0 || bus.MemAddr !== '0 || bus.OutData !== '0) begin
      failures++;
      $display("FAIL rstmid_outputs got=%b/%0h/%0h want=0", {bus.MemRd, bus.OutValid, Busy, Done, Err}, bus.MemAddr, bus.OutData);
    end
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    pushModel(2, 4, 4, 1);
    runJob(2, 4, 4, 1, 1'b0, dones, busyAfter, timedOut);
    checks++; if (gotQ.size() != 9) begin failures++; $display("FAIL rstmid_count got=%0d want=9", gotQ.size()); end
    while (expQ.size() > 0 && gotQ.size() > 0) begin
      e = expQ.pop_front(); g = gotQ.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL rstmid_data got=%0d want=%0d", g, e); end
    end
    checks++; if (dones != 1 || timedOut) begin failures++; $display("FAIL rstmid_done got=%0d want=1", dones); end
  endtask

  initial begin
    bus.OutReady = 1'b1;
    test_reset();
    test_basic();
    test_stride();
    test_signed_backpressure();
    test_config_error();
    test_var_latency();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
